// File: rtl/ps2_device_if.sv
// ps2_device_if
//   Core-side handshake bundle between the PS/2 device block and the
//   emulated keyboard/mouse core.
//   master modport: the emulated-device core (drives tx_data/tx_valid)
//   slave modport : ps2_device itself
//   Signals:
//     tx_data  [7:0]  byte to send to the host
//     tx_valid        tx_data valid, accepted when tx_valid & tx_ready
//     tx_ready        no byte pending and the link FSM is idle
//     tx_done         1-cycle pulse, pending byte fully sent
//     rx_data  [7:0]  last host byte received
//     rx_valid        1-cycle pulse, rx_data updated
//     rx_err          1-cycle pulse, host frame error
//     busy            link FSM not idle
interface ps2_device_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_done, rx_data, rx_valid, rx_err, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_done, rx_data, rx_valid, rx_err, busy
  );
endinterface

// File: rtl/ps2_device.sv
// ps2_device
//   Device end of a PS/2 link (keyboard/mouse emulator). Generates the PS/2
//   clock, sends bytes to the host and receives host commands after a
//   request-to-send, acknowledging them. Pads are open collector: a *_q of 1
//   pulls the line low, *_d inputs are the raw pad levels.
// Parameters:
//   HALF_CYC  clk cycles per PS/2 clock half-period
//   IDLE_CYC  clk cycles both lines must be high before a transmission starts
// Ports:
//   clk, rst_n             system clock, synchronous active-low reset
//   ps2_clk_d, ps2_data_d  pad levels (asynchronous, double-flopped here)
//   ps2_clk_q, ps2_data_q  registered pull-low enables for the pads
//   bus                    ps2_device_if.slave core-side handshake bundle
// Configuration:
//   PS2_DEV_PARITY_CHECK_EN  when defined, a received frame with even parity
//   is still ACKed but reported through rx_err instead of rx_valid.
module ps2_device #(
  parameter int HALF_CYC = 2000,
  parameter int IDLE_CYC = 2500
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ps2_clk_d,
  input  logic         ps2_data_d,
  output logic         ps2_clk_q,
  output logic         ps2_data_q,
  ps2_device_if.slave  bus
);

  localparam int MAX_CYC = (HALF_CYC > IDLE_CYC) ? HALF_CYC : IDLE_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] IDLE_MAX  = CW'(IDLE_CYC);
  localparam logic [CW-1:0] GRACE     = CW'(2);
  localparam logic [CW-1:0] ONE       = CW'(1);

`ifdef PS2_DEV_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, TX_HI, TX_LO, TX_END, RX_LO, RX_HI, RX_ACK_LO, RX_ACK_HI, RX_FLUSH
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, idle_cnt;
  logic [3:0]    bit_idx, bit_nxt;
  logic          clk_meta, data_meta, clk_s, data_s;
  logic          pending, pending_nxt;
  logic [7:0]    tx_hold, rx_data_r;
  logic [8:0]    rx_shift;
  logic [10:0]   tx_frame;
  logic          phase_end, host_hold, accept, sample_en;
  logic          parity_ok, frame_ok, tx_fin, rx_fin, flush_exit;
  logic          clk_q_n, data_q_n, tx_ready_n, busy_n;
  logic          tx_ready_r, tx_done_r, rx_valid_r, rx_err_r, busy_r;

  // Two-flop synchronisers for the pad levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_meta  <= 1'b0;
      clk_s     <= 1'b0;
      data_meta <= 1'b0;
      data_s    <= 1'b0;
    end else begin
      clk_meta  <= ps2_clk_d;
      clk_s     <= clk_meta;
      data_meta <= ps2_data_d;
      data_s    <= data_meta;
    end
  end

  // Bus-idle timer: saturates so a long idle bus keeps TX permission.
  always_ff @(posedge clk) begin
    if (!rst_n)
      idle_cnt <= '0;
    else if (clk_s && data_s) begin
      if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + ONE;
    end else
      idle_cnt <= '0;
  end

  assign phase_end = (cnt == HALF_LAST);
  // The first two cycles of a HIGH phase still show our own pull-low
  // through the synchroniser, so a low clock then is not the host.
  assign host_hold = (cnt >= GRACE) && !clk_s;
  assign accept    = bus.tx_valid && tx_ready_r;
  assign tx_frame  = {1'b1, ~^tx_hold, tx_hold, 1'b0};
  assign parity_ok = ^rx_shift;
  assign frame_ok  = parity_ok || !PARITY_EN;
  assign tx_fin    = (state == TX_END) && phase_end;
  assign rx_fin    = (state == RX_ACK_HI) && phase_end && !host_hold;
  assign flush_exit = (state == RX_FLUSH) && phase_end && bit_idx[0] && data_s;
  assign sample_en = (state == RX_HI) && phase_end && !host_hold && (bit_idx != 4'd9);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
    end
  end

  // Next-state logic. In IDLE, cnt is a short settle timer so that data
  // we just released (after an ACK) is not mistaken for a host RTS.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = phase_end ? '0 : cnt + ONE;
    bit_nxt     = bit_idx;
    pending_nxt = (pending || accept) && !tx_fin;
    case (state)
      IDLE: begin
        bit_nxt = '0;
        cnt_nxt = (cnt < GRACE) ? cnt + ONE : cnt;
        if (cnt >= GRACE) begin
          if (clk_s && !data_s) begin
            state_nxt = RX_LO;
            cnt_nxt   = '0;
          end else if (pending && (idle_cnt == IDLE_MAX)) begin
            state_nxt = TX_HI;
            cnt_nxt   = '0;
          end
        end
      end
      TX_HI: begin
        if (host_hold) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (phase_end)
          state_nxt = TX_LO;
      end
      TX_LO: begin
        if (phase_end) begin
          if (bit_idx == 4'd10)
            state_nxt = TX_END;
          else begin
            bit_nxt   = bit_idx + 4'd1;
            state_nxt = TX_HI;
          end
        end
      end
      TX_END: begin
        if (phase_end)
          state_nxt = IDLE;
      end
      RX_LO: begin
        if (phase_end)
          state_nxt = RX_HI;
      end
      RX_HI: begin
        if (host_hold) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (phase_end) begin
          if (bit_idx == 4'd9) begin
            bit_nxt   = '0;
            state_nxt = data_s ? RX_ACK_LO : RX_FLUSH;
          end else begin
            bit_nxt   = bit_idx + 4'd1;
            state_nxt = RX_LO;
          end
        end
      end
      RX_ACK_LO: begin
        if (phase_end)
          state_nxt = RX_ACK_HI;
      end
      RX_ACK_HI: begin
        if (host_hold) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (phase_end)
          state_nxt = IDLE;
      end
      RX_FLUSH: begin
        // bit_idx[0] tracks LOW (0) / HIGH (1) while clocking out a bad frame.
        if (phase_end) begin
          if (bit_idx[0] && data_s)
            state_nxt = IDLE;
          else
            bit_nxt = bit_idx ^ 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic, decoded from the upcoming state so the registered pad
  // drives change on the same edge as the state.
  always_comb begin
    clk_q_n    = 1'b0;
    data_q_n   = 1'b0;
    busy_n     = (state_nxt != IDLE);
    tx_ready_n = (state_nxt == IDLE) && !pending_nxt;
    case (state_nxt)
      TX_HI:     data_q_n = ~tx_frame[bit_nxt];
      TX_LO: begin
        clk_q_n  = 1'b1;
        data_q_n = ~tx_frame[bit_nxt];
      end
      RX_LO:     clk_q_n = 1'b1;
      RX_ACK_LO: begin
        clk_q_n  = 1'b1;
        data_q_n = 1'b1;
      end
      RX_ACK_HI: data_q_n = 1'b1;
      RX_FLUSH:  clk_q_n = ~bit_nxt[0];
      default: begin
        clk_q_n  = 1'b0;
        data_q_n = 1'b0;
      end
    endcase
  end

  // Datapath: pending byte, receive shifter, received byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      tx_hold   <= '0;
      rx_shift  <= '0;
      rx_data_r <= '0;
    end else begin
      pending <= pending_nxt;
      if (accept)
        tx_hold <= bus.tx_data;
      if (sample_en)
        rx_shift <= {data_s, rx_shift[8:1]};
      if (rx_fin && frame_ok)
        rx_data_r <= rx_shift[7:0];
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps2_clk_q  <= 1'b0;
      ps2_data_q <= 1'b0;
      tx_ready_r <= 1'b0;
      tx_done_r  <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      ps2_clk_q  <= clk_q_n;
      ps2_data_q <= data_q_n;
      tx_ready_r <= tx_ready_n;
      tx_done_r  <= tx_fin;
      rx_valid_r <= rx_fin && frame_ok;
      rx_err_r   <= (rx_fin && !frame_ok) || flush_exit;
      busy_r     <= busy_n;
    end
  end

  assign bus.tx_ready = tx_ready_r;
  assign bus.tx_done  = tx_done_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.rx_err   = rx_err_r;
  assign bus.busy     = busy_r;

endmodule
